// File: rtl/main_controller.sv
// Multi-cycle control FSM: FETCH, DECODE, EXEC, MEM, WB, HALT; Moore outputs from state and irOut.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module main_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] irOut,
   input  logic        comparatorOut,
   output logic        pcEn,
   output logic [1:0]  pcSelect,
   output logic        regWrite,
   output logic        aluSrc,
   output logic        ramRdEn,
   output logic        ramWrEn,
   output logic        isByte,
   output logic        isHalf,
   output logic        isWord,
   output logic [1:0]  memToReg,
   output logic        halted
`ifdef INSTR_COUNT_EN
   ,
   output logic [31:0] instrCount
`endif
);

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   state_t state, next_state;

   logic [6:0] opcode;
   logic [1:0] size;
   logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, legal;
   logic unused_ir;

   assign opcode    = irOut[6:0];
   assign size      = irOut[13:12];
   assign unused_ir = ^{irOut[31:14], irOut[11:7]};

   assign is_r      = (opcode == 7'b0110011);
   assign is_i      = (opcode == 7'b0010011);
   assign is_load   = (opcode == 7'b0000011);
   assign is_store  = (opcode == 7'b0100011);
   assign is_branch = (opcode == 7'b1100011);
   assign is_jal    = (opcode == 7'b1101111);
   assign is_jalr   = (opcode == 7'b1100111);
   assign is_lui    = (opcode == 7'b0110111);
   assign legal     = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr | is_lui;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   // Outputs are forced low while reset is high so a pending write is never seen.
   always_comb begin
      next_state = state;
      pcEn       = 1'b0;
      pcSelect   = 2'b00;
      regWrite   = 1'b0;
      aluSrc     = 1'b0;
      ramRdEn    = 1'b0;
      ramWrEn    = 1'b0;
      isByte     = 1'b0;
      isHalf     = 1'b0;
      isWord     = 1'b0;
      memToReg   = 2'b00;
      halted     = 1'b0;
      if (!reset) begin
         case (state)
            FETCH:  next_state = DECODE;
            DECODE: next_state = legal ? EXEC : HALT;
            EXEC: begin
               aluSrc = is_i | is_load | is_store | is_jalr;
               if (is_branch) begin
                  pcEn       = 1'b1;
                  pcSelect   = comparatorOut ? 2'b01 : 2'b00;
                  next_state = FETCH;
               end else if (is_load || is_store) begin
                  next_state = MEM;
               end else if (legal) begin
                  next_state = WB;
               end else begin
                  next_state = HALT;
               end
            end
            MEM: begin
               if (size == 2'b11 || !(is_load || is_store)) begin
                  next_state = HALT;
               end else begin
                  isByte = (size == 2'b00);
                  isHalf = (size == 2'b01);
                  isWord = (size == 2'b10);
                  if (is_load) begin
                     ramRdEn    = 1'b1;
                     next_state = WB;
                  end else begin
                     ramWrEn    = 1'b1;
                     pcEn       = 1'b1;
                     next_state = FETCH;
                  end
               end
            end
            WB: begin
               regWrite   = 1'b1;
               pcEn       = 1'b1;
               next_state = FETCH;
               if (is_load) begin
                  memToReg = 2'b01;
               end else if (is_jal) begin
                  memToReg = 2'b10;
                  pcSelect = 2'b01;
               end else if (is_jalr) begin
                  memToReg = 2'b10;
                  pcSelect = 2'b10;
               end else if (is_lui) begin
                  memToReg = 2'b11;
               end
            end
            HALT: begin
               halted     = 1'b1;
               next_state = HALT;
            end
            default: next_state = FETCH;
         endcase
      end
   end

`ifdef INSTR_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)     instrCount <= '0;
      else if (pcEn) instrCount <= instrCount + 32'd1;
   end
`endif

endmodule

// File: doc/main_controller.md
MAIN_CONTROLLER -- requirements
Module: main_controller

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 irOut  input  32  current instruction word from the instruction memory.
REQ-004 comparatorOut  input  1  branch condition result from the comparator.
REQ-005 pcEn  output  1  one-cycle pulse that advances the program counter.
REQ-006 pcSelect  output  2  PC source; 00 PC+4, 01 PC+imm, 10 ALU result, 11 unused.
REQ-007 regWrite  output  1  register file write strobe.
REQ-008 aluSrc  output  1  ALU operand 2 select; 1 immediate, 0 rs2.
REQ-009 ramRdEn, ramWrEn  output  1 each  data memory read and write enables.
REQ-010 isByte, isHalf, isWord  output  1 each  access size; one-hot while a memory access is active, else all 0.
REQ-011 memToReg  output  2  writeback select; 00 ALU, 01 data memory, 10 PC link, 11 immediate.
REQ-012 halted  output  1  high while the FSM is in HALT.
REQ-013 instrCount  output  32  retired-instruction count; present only with INSTR_COUNT_EN.

Function
REQ-014 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; outputs are Moore functions of the state register and irOut.
REQ-015 FETCH->DECODE unconditionally; the one FETCH cycle covers the instruction memory latency.
REQ-016 DECODE SHALL classify irOut[6:0]: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI; any other opcode goes to HALT.
REQ-017 DECODE->EXEC for all legal opcodes.
REQ-018 EXEC: aluSrc=1 for I-ALU, load, store, JALR; aluSrc=0 for R and branch.
REQ-019 EXEC->MEM for load/store; EXEC->WB for R, I-ALU, JAL, JALR, LUI.
REQ-020 Branch SHALL retire in EXEC with pcEn=1; pcSelect=01 if comparatorOut=1, else 00; next state FETCH.
REQ-021 MEM: size from irOut[13:12]: 00 isByte, 01 isHalf, 10 isWord; 11 is illegal and goes to HALT with no enable asserted.
REQ-022 MEM, load: ramRdEn=1, next state WB.
REQ-023 MEM, store: ramWrEn=1, pcEn=1, pcSelect=00, next state FETCH.
REQ-024 WB SHALL assert regWrite=1 and pcEn=1 for one cycle; next state FETCH.
REQ-025 WB memToReg/pcSelect: R, I-ALU 00/00; load 01/00; JAL 10/01; JALR 10/10; LUI 11/00.
REQ-026 Outputs not named for the current state/class SHALL be 0; ramRdEn and ramWrEn are never both 1.
REQ-027 Latency: branch 3 cycles; store, R, I-ALU, JAL, JALR, LUI 4 cycles; load 5 cycles.
REQ-028 HALT: all enables 0, halted=1, no exit except reset.

Reset
REQ-029 reset=1 at a clock edge SHALL force FETCH from any state, including mid-instruction, cancelling any pending write.
REQ-030 While reset=1 and in the cycle after it deasserts: all outputs 0 and halted=0; instrCount reads 0 when present.

Configuration
REQ-031 Macro INSTR_COUNT_EN defined: instrCount is present, increments by 1 (mod 2^32, wrapping) on every cycle with pcEn=1, holds in HALT, and clears on reset.
REQ-032 INSTR_COUNT_EN undefined: the instrCount port and counter are absent; all other behaviour is identical.

Verification
REQ-033 Reset, then irOut=0x002081B3 (add x3,x1,x2) -> FETCH, DECODE, EXEC, WB; regWrite=1, pcEn=1, memToReg=00 only in cycle 4.
REQ-034 irOut=0x0040A183 (lw) -> cycle 4 ramRdEn=1, isWord=1; cycle 5 regWrite=1, memToReg=01, pcEn=1.
REQ-035 irOut=0x00208463 (beq) with comparatorOut=1 -> cycle 3 pcEn=1, pcSelect=01; with comparatorOut=0 -> pcSelect=00; regWrite=0 in both cases.
REQ-036 irOut=0x00209023 (sh) -> cycle 4 ramWrEn=1, isHalf=1, pcEn=1; regWrite never asserted.
REQ-037 irOut=0x00000017 (AUIPC, not a supported opcode) -> HALT after DECODE, halted=1 and held; reset asserted in EXEC of the next add -> FETCH next cycle with no regWrite.
REQ-038 INSTR_COUNT_EN defined: 3 adds then 1 load -> instrCount=4 after 17 cycles.
